ahblite_oled_spi_slave: RTL and testbench
=========================================

# ahblite_oled_spi_slave

AHB-Lite responder that terminates the OLED port of the bus matrix and drives a 4-wire SPI OLED panel (SSD1306-class). Bus writes to the command and data registers become SPI bytes with the D/C line set accordingly. A one-byte holding register sits ahead of the serialiser. When the holding register is full, the block inserts HREADYOUT wait states instead of dropping bytes.

## Interface
- DIV_RESET, 8'd3: reset value of the SCLK divider, CTRL[7:0].
- HCLK  in  1  system clock; all logic on its rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from the matrix output stage.
- HADDR  in  32  address; only HADDR[3:2] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 is an active transfer.
- HWRITE  in  1  1=write.
- HSIZE  in  3  ignored; all registers are word-wide.
- HBURST  in  3  ignored.
- HPROT  in  4  ignored.
- HREADY  in  1  bus ready from the matrix.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYOUT  out  1  slave ready/wait.
- HRDATA  out  32  read data.
- HRESP  out  1  0=OKAY, 1=ERROR.
- OLED_SCLK  out  1  SPI clock, mode 0.
- OLED_SDIN  out  1  SPI data, MSB first.
- OLED_CS_N  out  1  chip select, active low.
- OLED_DC  out  1  0=command byte, 1=data byte.
- OLED_RES_N  out  1  panel reset, active low.

## Operation
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. Register HADDR[3:2] and HWRITE for the data phase.
- Register map by HADDR[3:2]:
  - 0: CMD (W). Byte HWDATA[7:0] is sent with DC=0.
  - 1: DATA (W). Byte HWDATA[7:0] is sent with DC=1.
  - 2: CTRL (RW). [7:0] div, [8] res_n drives OLED_RES_N, [9] en.
  - 3: STATUS (R). [0] busy (serialiser active), [1] hold_full.
- Reads of CMD and DATA return 0. Unused read bits return 0.
- Write to CMD/DATA, data phase, hold empty: capture the byte plus its DC into hold. hold_full is set. HREADYOUT=1.
- Write to CMD/DATA, data phase, hold full: HREADYOUT=0 until the serialiser takes the held byte. Capture on the first cycle hold is empty; HREADYOUT=1 that cycle.
- Serialiser FSM states: IDLE, LOAD, LOW, HIGH, GAP.
  - IDLE: when en & hold_full, go to LOAD.
  - LOAD: hold moves into the shifter and hold_full clears. OLED_CS_N=0, OLED_DC=held DC, OLED_SDIN=bit7, bitcnt=0. Go to LOW.
  - LOW: SCLK=0 for div+1 cycles, then go to HIGH.
  - HIGH: SCLK=1 for div+1 cycles. On exit, shift left and increment bitcnt. Return to LOW while bitcnt<8; otherwise go to GAP.
  - GAP: CS_N=1 and SCLK=0 for div+1 cycles, then go to IDLE.
- busy = state≠IDLE.
- Clearing en mid-byte: the current byte completes. No new LOAD occurs while en=0.
- Writing div mid-byte takes effect at the next half-period start.

## Timing
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - OLED_SCLK=0, OLED_SDIN=0, OLED_CS_N=1, OLED_DC=0, OLED_RES_N=0.
  - div=DIV_RESET, en=0, hold empty, FSM in IDLE.
- Reset asserted mid-byte: all of the above apply on the next edge. The partial byte is discarded.
- Read data is valid in the first data-phase cycle. Reads have zero wait states.
- Byte time from LOAD to IDLE is 1+17×(div+1) HCLK cycles.
- Back-to-back: LOAD may occur in the cycle after GAP→IDLE. Gap between bytes is div+1 cycles of CS_N high plus 1 IDLE cycle.
- Hold frees and a stalled write arrives in the same cycle: the write is captured and hold stays full (new byte). HREADYOUT=1.
- HRDATA is driven only during a read data phase. It is 0 otherwise.

## Configuration
- OLED_HRESP_ERR_EN defined:
  - Writes to STATUS give the two-cycle AHB ERROR response. Cycle 1: HREADYOUT=0, HRESP=1. Cycle 2: HREADYOUT=1, HRESP=1.
  - Reads with HADDR[1:0]≠0 give the same response.
  - No state changes on an errored access.
- OLED_HRESP_ERR_EN undefined: those accesses complete OKAY with zero waits. STATUS writes are ignored, and misaligned accesses decode on HADDR[3:2].

## Structure
- Shared package `oled_pkg`:
  - register offset constants REG_CMD/REG_DATA/REG_CTRL/REG_STATUS.
  - CTRL bit positions.
  - serialiser state enum.
- Sub-module `oled_spi_serialiser`:
  - Contains the FSM, divider counter, shifter, and bit counter.
  - Inputs: byte, dc, valid, div, en.
  - Outputs: take, busy, and the four SPI pins.
- The top level holds the AHB decode, the hold register, CTRL, and the wait/ERROR logic.

## Test plan
- Reset, then read CTRL → 0x00000003. Read STATUS → 0. OLED_CS_N=1, OLED_RES_N=0.
- Write CTRL=0x300 (en, res_n, div=0), then write DATA=0xA5. Expected: OLED_DC=1 and CS_N low for 17 cycles. SDIN sampled on SCLK rising edges = 1,0,1,0,0,1,0,1.
- With div=0, write CMD=0xAE, then DATA=0x01, then DATA=0x02 back-to-back. Expected: the third write stalls with HREADYOUT=0 until LOAD of the second byte. Three bytes appear in order with DC=0,1,1.
- Write DATA with en=0: STATUS reads 0x2 and there is no SPI activity. Then set en: the byte is sent and STATUS returns to 0 after 1+17×(div+1) cycles.
- Assert HRESET mid-byte: all outputs return to reset values next cycle, and hold_full=0.
- With OLED_HRESP_ERR_EN: write STATUS → HRESP=1 for two cycles, HREADYOUT 0 then 1. Without the macro: OKAY with no wait.

Source files
------------

// File: rtl/oled_pkg.sv
// ---------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the AHB-Lite OLED SPI responder:
//   - register offsets decoded from HADDR[3:2]
//   - CTRL register bit positions
//   - serialiser FSM state encoding
//   - ctrl_word(): packs the CTRL fields into a 32-bit read word
// ---------------------------------------------------------------------------
package oled_pkg;

    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_DIV_LSB   = 0;
    localparam int CTRL_DIV_MSB   = 7;
    localparam int CTRL_RES_N_BIT = 8;
    localparam int CTRL_EN_BIT    = 9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LOW  = 3'd2,
        ST_HIGH = 3'd3,
        ST_GAP  = 3'd4
    } ser_state_t;

    function automatic logic [31:0] ctrl_word(input logic [7:0] div,
                                              input logic       res_n,
                                              input logic       en);
        logic [31:0] w;
        w = '0;
        w[CTRL_DIV_MSB:CTRL_DIV_LSB] = div;
        w[CTRL_RES_N_BIT]            = res_n;
        w[CTRL_EN_BIT]               = en;
        return w;
    endfunction

endpackage

// File: rtl/oled_spi_serialiser.sv
// ---------------------------------------------------------------------------
// oled_spi_serialiser
// SPI mode-0 byte serialiser, MSB first, with chip select framing and a
// D/C line latched per byte. Each SCLK half-period and the inter-byte gap
// last (div+1) clock cycles; div is sampled at the start of every half.
//
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_byte, i_dc   byte and D/C from the holding register
//   i_valid        holding register full
//   i_div          SCLK half-period divider
//   i_en           allows a new byte to start
//   o_take         high for the one cycle the held byte is consumed
//   o_busy         FSM not idle
//   o_sclk, o_sdin, o_cs_n, o_dc   SPI pins (registered)
// ---------------------------------------------------------------------------
module oled_spi_serialiser (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    input  logic       i_dc,
    input  logic       i_valid,
    input  logic [7:0] i_div,
    input  logic       i_en,
    output logic       o_take,
    output logic       o_busy,
    output logic       o_sclk,
    output logic       o_sdin,
    output logic       o_cs_n,
    output logic       o_dc
);
    import oled_pkg::*;

    ser_state_t r_state;
    logic [7:0] r_shift;
    logic [7:0] r_cnt;
    logic [3:0] r_bitcnt;
    logic       r_sclk;
    logic       r_sdin;
    logic       r_cs_n;
    logic       r_dc;
    logic       w_half_done;

    // r_cnt counts down from the divider value latched at the half start
    assign w_half_done = (r_cnt == 8'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 8'd0;
            r_bitcnt <= 4'd0;
            r_sclk   <= 1'b0;
            r_sdin   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_dc     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Pins take their LOAD values on entry so they are
                    // already valid during the LOAD cycle itself.
                    if (i_en && i_valid) begin
                        r_state  <= ST_LOAD;
                        r_cs_n   <= 1'b0;
                        r_dc     <= i_dc;
                        r_sdin   <= i_byte[7];
                        r_bitcnt <= 4'd0;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_LOW;
                    r_cnt   <= i_div;
                end
                ST_LOW: begin
                    if (w_half_done) begin
                        r_state <= ST_HIGH;
                        r_sclk  <= 1'b1;
                        r_cnt   <= i_div;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (w_half_done) begin
                        r_sclk   <= 1'b0;
                        r_cnt    <= i_div;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            r_state <= ST_GAP;
                            r_cs_n  <= 1'b1;
                            r_sdin  <= 1'b0;
                        end else begin
                            r_state <= ST_LOW;
                            r_sdin  <= r_shift[6];
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (w_half_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Shifter: the held byte is still stable during LOAD, since the holding
    // register can only be overwritten at the end of the take cycle.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_LOAD) begin
            r_shift <= i_byte;
        end else if ((r_state == ST_HIGH) && w_half_done) begin
            r_shift <= {r_shift[6:0], 1'b0};
        end
    end

    assign o_take = (r_state == ST_LOAD);
    assign o_busy = (r_state != ST_IDLE);
    assign o_sclk = r_sclk;
    assign o_sdin = r_sdin;
    assign o_cs_n = r_cs_n;
    assign o_dc   = r_dc;

endmodule

// File: rtl/ahblite_oled_spi_slave.sv
// ---------------------------------------------------------------------------
// ahblite_oled_spi_slave
// AHB-Lite responder driving a 4-wire SPI OLED panel. Writes to CMD (DC=0)
// or DATA (DC=1) pass through a one-byte holding register into the
// serialiser; a write that finds the holding register full is stretched
// with HREADYOUT wait states until the serialiser takes the held byte.
//
// Register map (HADDR[3:2]): 0 CMD (W), 1 DATA (W),
//   2 CTRL (RW: [7:0] div, [8] res_n, [9] en), 3 STATUS (R: [0] busy,
//   [1] hold_full).
//
// Optional feature macro OLED_HRESP_ERR_EN: STATUS writes and reads with
// HADDR[1:0]!=0 get a two-cycle ERROR response and change no state. Without
// it those accesses complete OKAY (STATUS writes ignored).
//
// Ports: AHB-Lite slave interface (HCLK, HRESET sync active-high, HSEL,
// HADDR, HTRANS, HWRITE, HSIZE/HBURST/HPROT unused, HREADY, HWDATA,
// HREADYOUT, HRDATA, HRESP) and panel pins OLED_SCLK, OLED_SDIN,
// OLED_CS_N, OLED_DC, OLED_RES_N.
// ---------------------------------------------------------------------------
module ahblite_oled_spi_slave #(
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        OLED_SCLK,
    output logic        OLED_SDIN,
    output logic        OLED_CS_N,
    output logic        OLED_DC,
    output logic        OLED_RES_N
);
    import oled_pkg::*;

    logic       r_dp_active;
    logic       r_dp_write;
    logic [1:0] r_dp_addr;
    logic       r_hold_full;
    logic       r_hold_dc;
    logic [7:0] r_hold_byte;
    logic [7:0] r_div;
    logic       r_res_n;
    logic       r_en;

    logic w_accept;
    logic w_take;
    logic w_busy;
    logic w_dp_bad;
    logic w_err_wait;
    logic w_dp_ok;
    logic w_wr_byte;
    logic w_wr_ctrl;
    logic w_stall;
    logic w_capture;
    logic w_unused;

    assign w_unused = ^{HSIZE, HBURST, HPROT, HADDR[31:4], HADDR[1:0],
                        HTRANS[0], HWDATA[31:10]};

    assign w_accept = HSEL & HTRANS[1] & HREADY;

    // Address phase -> data phase registers; held while the bus is stalled
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_active <= 1'b0;
        end else if (HREADY) begin
            r_dp_active <= w_accept;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HREADY) begin
            r_dp_write <= HWRITE;
            r_dp_addr  <= HADDR[3:2];
        end
    end

`ifdef OLED_HRESP_ERR_EN
    logic r_dp_misalign;
    logic r_err2;

    always_ff @(posedge HCLK) begin
        if (HREADY) begin
            r_dp_misalign <= |HADDR[1:0];
        end
    end

    assign w_dp_bad = r_dp_active &
                      ((r_dp_write & (r_dp_addr == REG_STATUS)) |
                       (~r_dp_write & r_dp_misalign));

    // r_err2 marks the second (HREADYOUT=1) cycle of the ERROR response
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_err2 <= 1'b0;
        end else begin
            r_err2 <= w_dp_bad & ~r_err2;
        end
    end

    assign w_err_wait = w_dp_bad & ~r_err2;
`else
    assign w_dp_bad   = 1'b0;
    assign w_err_wait = 1'b0;
`endif

    assign w_dp_ok   = r_dp_active & ~w_dp_bad;
    assign w_wr_byte = w_dp_ok & r_dp_write & ~r_dp_addr[1];
    assign w_wr_ctrl = w_dp_ok & r_dp_write & (r_dp_addr == REG_CTRL);
    // A take in the same cycle frees the slot, so the write lands at once
    assign w_stall   = w_wr_byte & r_hold_full & ~w_take;
    assign w_capture = w_wr_byte & ~w_stall;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hold_full <= 1'b0;
        end else if (w_capture) begin
            r_hold_full <= 1'b1;
        end else if (w_take) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_capture) begin
            r_hold_byte <= HWDATA[7:0];
            r_hold_dc   <= (r_dp_addr == REG_DATA);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_div   <= DIV_RESET;
            r_res_n <= 1'b0;
            r_en    <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_div   <= HWDATA[CTRL_DIV_MSB:CTRL_DIV_LSB];
            r_res_n <= HWDATA[CTRL_RES_N_BIT];
            r_en    <= HWDATA[CTRL_EN_BIT];
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (w_dp_ok && !r_dp_write) begin
            case (r_dp_addr)
                REG_CTRL:   HRDATA = ctrl_word(r_div, r_res_n, r_en);
                REG_STATUS: HRDATA = {30'd0, r_hold_full, w_busy};
                default:    HRDATA = 32'd0;
            endcase
        end
    end

    assign HREADYOUT  = ~w_err_wait & ~w_stall;
    assign HRESP      = w_dp_bad;
    assign OLED_RES_N = r_res_n;

    oled_spi_serialiser u_ser (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_byte  (r_hold_byte),
        .i_dc    (r_hold_dc),
        .i_valid (r_hold_full),
        .i_div   (r_div),
        .i_en    (r_en),
        .o_take  (w_take),
        .o_busy  (w_busy),
        .o_sclk  (OLED_SCLK),
        .o_sdin  (OLED_SDIN),
        .o_cs_n  (OLED_CS_N),
        .o_dc    (OLED_DC)
    );

endmodule

// File: tb/tb_ahblite_oled_spi_slave.sv
module tb_ahblite_oled_spi_slave;

    localparam logic [31:0] A_CMD    = 32'h0;
    localparam logic [31:0] A_DATA   = 32'h4;
    localparam logic [31:0] A_CTRL   = 32'h8;
    localparam logic [31:0] A_STATUS = 32'hC;

    logic        clk;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        OLED_SCLK;
    logic        OLED_SDIN;
    logic        OLED_CS_N;
    logic        OLED_DC;
    logic        OLED_RES_N;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_rd[$];
    logic [8:0]  exp_spi[$];   // {dc, byte}

    logic tb_rd_dp;

    ahblite_oled_spi_slave #(.DIV_RESET(8'd3)) dut (
        .HCLK       (clk),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HPROT      (HPROT),
        .HREADY     (HREADYOUT),
        .HWDATA     (HWDATA),
        .HREADYOUT  (HREADYOUT),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP),
        .OLED_SCLK  (OLED_SCLK),
        .OLED_SDIN  (OLED_SDIN),
        .OLED_CS_N  (OLED_CS_N),
        .OLED_DC    (OLED_DC),
        .OLED_RES_N (OLED_RES_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Bus-side tracking of a read data phase (single slave: HREADY = HREADYOUT)
    always @(posedge clk) begin
        if (HRESET) tb_rd_dp <= 1'b0;
        else if (HREADYOUT) tb_rd_dp <= HSEL & HTRANS[1] & ~HWRITE;
    end

    // Monitor: read data and SPI bytes, compared against the scoreboard queues
    initial begin
        logic       sclk_q;
        logic       cs_q;
        int         bits;
        logic [7:0] sh;
        logic       dc;
        logic [8:0] e;
        sclk_q = 1'b0;
        cs_q   = 1'b1;
        bits   = 0;
        sh     = 8'd0;
        dc     = 1'b0;
        forever begin
            @(negedge clk);
            if (tb_rd_dp === 1'b1 && HREADYOUT === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_unexpected: got 0x%08h with no expected value queued", HRDATA);
                end else begin
                    check("rd_data", HRDATA, exp_rd.pop_front());
                end
            end
            if (OLED_SCLK === 1'b1 && sclk_q === 1'b0) begin
                if (bits == 0) dc = OLED_DC;
                sh = {sh[6:0], OLED_SDIN};
                bits++;
            end
            if (OLED_CS_N === 1'b1 && cs_q === 1'b0) begin
                if (bits == 8) begin
                    if (exp_spi.size() == 0) begin
                        n_checks++;
                        $display("FAIL spi_unexpected: got dc=%0b byte=0x%02h with none queued", dc, sh);
                    end else begin
                        e = exp_spi.pop_front();
                        check("spi_byte", {23'd0, dc, sh}, {23'd0, e});
                    end
                end
                bits = 0;
            end
            sclk_q = OLED_SCLK;
            cs_q   = OLED_CS_N;
        end
    end

    // Bus tasks are entered and left at a negedge
    task automatic ahb_rd(input logic [31:0] addr, input logic [31:0] exp);
        int w;
        exp_rd.push_back(exp);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge clk);
        @(negedge clk);
        HSEL = 1'b0; HTRANS = 2'b00;
        w = 0;
        while (HREADYOUT !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check("rd_timeout", w, 0);
    endtask

    task automatic ahb_wr(input logic [31:0] addr, input logic [31:0] data,
                          output int stalls, output logic resp_first, output logic resp_last);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(posedge clk);
        @(negedge clk);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = data;
        resp_first = HRESP;
        stalls = 0;
        while (HREADYOUT !== 1'b1 && stalls < 200) begin
            @(negedge clk);
            stalls++;
        end
        resp_last = HRESP;
        if (stalls >= 200) check("wr_timeout", stalls, 0);
    endtask

    task automatic wait_cs_low(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (OLED_CS_N === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic cs_low_len(output int cnt);
        cnt = 0;
        while (OLED_CS_N === 1'b0 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   st;
        logic rf;
        logic rl;
        int   cnt;
        bit   found;

        HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HBURST = 3'd0; HPROT = 4'h3; HWDATA = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_hreadyout", HREADYOUT, 1);
        check("rst_hresp", HRESP, 0);
        check("rst_hrdata", HRDATA, 0);
        check("rst_cs_n", OLED_CS_N, 1);
        check("rst_res_n", OLED_RES_N, 0);
        check("rst_sclk", OLED_SCLK, 0);
        HRESET = 1'b0;

        ahb_rd(A_CTRL, 32'h3);
        ahb_rd(A_STATUS, 32'h0);
        ahb_rd(A_CMD, 32'h0);
        ahb_rd(A_DATA, 32'h0);

        // Single DATA byte, div=0
        ahb_wr(A_CTRL, 32'h300, st, rf, rl);
        ahb_rd(A_CTRL, 32'h300);
        check("res_n_driven", OLED_RES_N, 1);
        exp_spi.push_back({1'b1, 8'hA5});
        ahb_wr(A_DATA, 32'hA5, st, rf, rl);
        check("a5_wr_stall", st, 0);
        wait_cs_low(found);
        check("a5_started", found, 1);
        check("a5_dc", OLED_DC, 1);
        cs_low_len(cnt);
        check("a5_cs_low_cycles", cnt, 17);
        repeat (4) @(negedge clk);

        // Back-to-back CMD, DATA, DATA with div=0
        exp_spi.push_back({1'b0, 8'hAE});
        ahb_wr(A_CMD, 32'hAE, st, rf, rl);
        check("b2b_wr1_stall", st, 0);
        exp_spi.push_back({1'b1, 8'h01});
        ahb_wr(A_DATA, 32'h01, st, rf, rl);
        check("b2b_wr2_stall", st, 1);
        exp_spi.push_back({1'b1, 8'h02});
        ahb_wr(A_DATA, 32'h02, st, rf, rl);
        check("b2b_wr3_stall", st, 18);
        check("b2b_release_cs_n", OLED_CS_N, 0);
        check("b2b_release_dc", OLED_DC, 1);
        ahb_rd(A_STATUS, 32'h3);
        repeat (60) @(negedge clk);

        // div=1 byte
        ahb_wr(A_CTRL, 32'h301, st, rf, rl);
        exp_spi.push_back({1'b1, 8'h5A});
        ahb_wr(A_DATA, 32'h5A, st, rf, rl);
        wait_cs_low(found);
        check("div1_started", found, 1);
        cs_low_len(cnt);
        check("div1_cs_low_cycles", cnt, 33);
        repeat (10) @(negedge clk);

        // Held byte with en=0, then release with en=1
        ahb_wr(A_CTRL, 32'h100, st, rf, rl);
        exp_spi.push_back({1'b1, 8'h3C});
        ahb_wr(A_DATA, 32'h3C, st, rf, rl);
        ahb_rd(A_STATUS, 32'h2);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (OLED_CS_N !== 1'b1) cnt++;
        end
        check("en0_no_spi", cnt, 0);
        ahb_wr(A_CTRL, 32'h300, st, rf, rl);
        wait_cs_low(found);
        check("en1_started", found, 1);
        repeat (16) @(negedge clk);
        ahb_rd(A_STATUS, 32'h1);
        ahb_rd(A_STATUS, 32'h0);
        repeat (4) @(negedge clk);

        // Reset in the middle of a byte with another byte held
        ahb_wr(A_DATA, 32'hFF, st, rf, rl);
        ahb_wr(A_DATA, 32'h7E, st, rf, rl);
        repeat (4) @(negedge clk);
        check("pre_rst_cs_n", OLED_CS_N, 0);
        HRESET = 1'b1;
        @(negedge clk);
        check("mid_rst_cs_n", OLED_CS_N, 1);
        check("mid_rst_sclk", OLED_SCLK, 0);
        check("mid_rst_sdin", OLED_SDIN, 0);
        check("mid_rst_dc", OLED_DC, 0);
        check("mid_rst_res_n", OLED_RES_N, 0);
        check("mid_rst_hreadyout", HREADYOUT, 1);
        check("mid_rst_hresp", HRESP, 0);
        HRESET = 1'b0;
        ahb_rd(A_STATUS, 32'h0);
        ahb_rd(A_CTRL, 32'h3);

        // STATUS write and misaligned read
        ahb_wr(A_STATUS, 32'h3, st, rf, rl);
`ifdef OLED_HRESP_ERR_EN
        check("status_wr_waits", st, 1);
        check("status_wr_resp1", rf, 1);
        check("status_wr_resp2", rl, 1);
        ahb_rd(A_STATUS, 32'h0);
        ahb_rd(A_CTRL | 32'h1, 32'h0);
`else
        check("status_wr_waits", st, 0);
        check("status_wr_resp", rl, 0);
        ahb_rd(A_STATUS, 32'h0);
        ahb_rd(A_CTRL | 32'h1, 32'h3);
`endif

        repeat (40) @(negedge clk);
        check("spi_queue_drained", exp_spi.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
